fpu_sched: RTL and testbench
============================

Name: fpu_sched

Overview:
- Issue/writeback scheduler placed in front of the FPU datapath (fadd/fsub/fmul/fdiv/feq/flt/fle).
- Accepts one FP request per cycle from the core over a valid/ready handshake.
- Tracks each unit's fixed latency and holds back requests that would collide on the single writeback port.
- Serialises the non-pipelined divider, then emits a one-cycle writeback strobe carrying the destination tag and unit select.
- Moves no operand or result data; the datapath muxes data using dp_op and wb_op.

Parameters:
- LAT_ADD, 2, cycles from issue to writeback for ADD/SUB (pipelined).
- LAT_MUL, 3, cycles for MUL (pipelined).
- LAT_DIV, 8, cycles for DIV (non-pipelined; unit busy for the whole interval).
- LAT_CMP, 1, cycles for EQ/LT/LE and illegal ops.
- TAG_W, 5, destination register tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  core presents an FP op.
- req_ready  out  1  scheduler accepts the op this cycle.
- req_op  in  3  fpu_op_t opcode.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  kill all in-flight ops (pipeline redirect).
- dp_issue  out  1  datapath launch strobe; equals the handshake (req_valid & req_ready).
- dp_op  out  3  opcode launched; equals req_op when dp_issue is 1, else 0.
- wb_valid  out  1  writeback this cycle.
- wb_op  out  3  opcode whose result is written back; selects the unit result mux.
- wb_tag  out  TAG_W  destination tag of the writeback.
- wb_illegal  out  1  writeback is for an illegal opcode (result forced 0 by datapath).
- div_busy  out  1  divider occupied.
- inflight  out  4  number of accepted, not yet written-back ops.

Behaviour:
- Reset (asynchronous, while rst=1): req_ready=0, dp_issue=0, wb_valid=0, wb_op=0, wb_tag=0, wb_illegal=0, div_busy=0, inflight=0. All reservation slots are cleared.
- Opcode latency L(op):
  - ADD=0 and SUB=1 use LAT_ADD.
  - MUL=2 uses LAT_MUL.
  - DIV=3 uses LAT_DIV.
  - EQ=4, LT=5, LE=6 use LAT_CMP.
  - Opcode 7 is illegal: latency LAT_CMP, wb_illegal=1 at writeback.
- Handshake at cycle t (req_valid & req_ready) produces exactly one wb_valid pulse in cycle t+L(op), carrying that op's tag and opcode.
- req_ready is combinational from req_op and internal state. It equals 1 only if all of the following hold:
  - rst=0 and flush=0.
  - No in-flight op already owns writeback cycle t+L(req_op).
  - req_op is not DIV, or div_busy=0.
- req_valid may stay high while req_ready=0. Request fields must be held stable until the handshake.
- Writeback reservation: a shift register of depth max(latencies). Each entry holds {valid, op, tag, illegal}. It shifts toward the writeback end every cycle. At most one valid entry exists per writeback cycle.
- Divider:
  - div_busy goes to 1 in cycle t+1 after a DIV handshake at t.
  - It returns to 0 in cycle t+LAT_DIV, the same cycle as the DIV writeback.
  - A new DIV may handshake in cycle t+LAT_DIV.
- Mixed latencies: a short op issued after a long op may write back first. Results return out of order; the tag identifies each one.
- inflight:
  - Increments on a handshake and decrements on wb_valid.
  - A simultaneous handshake and writeback leaves it unchanged.
  - It never exceeds the reservation depth (8 with defaults), so the 4-bit width cannot wrap.
- flush:
  - On the cycle flush=1: no handshake, and wb_valid is suppressed that cycle.
  - At the clock edge, all reservation entries are cleared, div_busy=0 and inflight=0.
  - The core discards any results tied to killed tags.
- Mid-operation reset behaves like flush but asynchronously.
- There is no backpressure on writeback: the register-file write port always accepts.

Decomposition:
- Shared package fpu_pkg:
  - typedef enum fpu_op_t {ADD, SUB, MUL, DIV, EQ, LT, LE, ILL}.
  - Latency localparams and function fpu_lat(op).
  - Struct wb_slot_t {valid, op, tag, illegal}.
- One natural sub-module, fpu_wb_resv: the reservation shift register with a slot-occupied query port and an insert port. fpu_sched holds the handshake, divider occupancy counter and inflight counter.

Test Plan:
- Reset then ADD tag 3 at t=10 -> wb_valid at t=12 with wb_tag=3, wb_op=ADD; inflight 1 then 0.
- MUL tag 1 at t=0, then ADD tag 2 at t=1 (would write back at t=3, same as MUL) -> req_ready=0 at t=1. ADD accepted at t=2 and writes back at t=4; MUL writes back at t=3.
- DIV tag 4 at t=0, DIV tag 5 held valid -> req_ready=0 for t=1..7, accepted at t=8. Writebacks at t=8 and t=16; div_busy high t=1..7 and t=9..15, low at t=8.
- DIV tag 6 at t=0, EQ tag 7 at t=1 -> EQ writes back at t=2 before DIV at t=8 (out of order); inflight peaks at 2.
- ADD at t=0, MUL at t=1, flush at t=2 -> no wb_valid at t=2..6, inflight=0 and div_busy=0 at t=3, req_ready=1 at t=3.
- Opcode 7 tag 9 at t=0 -> wb_valid at t=1 with wb_illegal=1, wb_tag=9. Asserting rst during an outstanding DIV -> all outputs zero immediately, no later writeback.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared opcode, latency and writeback-slot definitions for the FPU scheduler
package fpu_pkg;

   localparam int TAG_W   = 5;
   localparam int LAT_ADD = 2;
   localparam int LAT_MUL = 3;
   localparam int LAT_DIV = 8;
   localparam int LAT_CMP = 1;

   localparam int LAT_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
   localparam int LAT_DC = (LAT_DIV > LAT_CMP) ? LAT_DIV : LAT_CMP;
   localparam int RESV_D = (LAT_AM > LAT_DC) ? LAT_AM : LAT_DC;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      MUL = 3'd2,
      DIV = 3'd3,
      EQ  = 3'd4,
      LT  = 3'd5,
      LE  = 3'd6,
      ILL = 3'd7
   } fpu_op_t;

   typedef struct packed {
      logic             valid;
      fpu_op_t          op;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } wb_slot_t;

   function automatic logic [3:0] fpu_lat(fpu_op_t op);
      return (op == ADD || op == SUB) ? 4'(LAT_ADD) :
             (op == MUL)              ? 4'(LAT_MUL) :
             (op == DIV)              ? 4'(LAT_DIV) : 4'(LAT_CMP);
   endfunction

endpackage

// File: rtl/fpu_wb_resv.sv
// fpu_wb_resv: writeback reservation shift register; slot i writes back i cycles from now
module fpu_wb_resv
   import fpu_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   input  logic     ins_valid,
   input  logic [3:0] ins_lat,
   input  wb_slot_t ins_slot,
   input  logic [3:0] qry_lat,
   output logic     qry_busy,
   output wb_slot_t head
);

   wb_slot_t slot_q [RESV_D];
   wb_slot_t slot_d [RESV_D];

   // Shift toward the head; a new op lands at lat-1 so it reaches slot 0 exactly lat cycles later
   always_comb begin
      qry_busy = 1'b0;
      head     = slot_q[0];
      for (int i = 0; i < RESV_D; i++) begin
         slot_d[i] = (i < RESV_D - 1) ? slot_q[(i + 1) % RESV_D] : '0;
         if (ins_valid && ins_lat == 4'(i + 1))
            slot_d[i] = ins_slot;
         if (flush)
            slot_d[i] = '0;
         qry_busy = qry_busy | (qry_lat == 4'(i) && slot_q[i].valid);
      end
   end

   // Slot state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RESV_D; i++)
            slot_q[i] <= '0;
      end else begin
         for (int i = 0; i < RESV_D; i++)
            slot_q[i] <= slot_d[i];
      end
   end

endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: FPU issue/writeback scheduler with writeback collision avoidance and divider serialisation
module fpu_sched
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             dp_issue,
   output logic [2:0]       dp_op,
   output logic             wb_valid,
   output logic [2:0]       wb_op,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_illegal,
   output logic             div_busy,
   output logic [3:0]       inflight
);

   fpu_op_t    op;
   logic [3:0] lat;
   logic       qry_busy;
   wb_slot_t   ins_slot;
   wb_slot_t   head;
   logic [3:0] div_cnt_q, div_cnt_d;
   logic [3:0] inflight_q, inflight_d;

   assign op  = fpu_op_t'(req_op);
   assign lat = fpu_lat(op);

   fpu_wb_resv u_resv (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .ins_valid (dp_issue),
      .ins_lat   (lat),
      .ins_slot  (ins_slot),
      .qry_lat   (lat),
      .qry_busy  (qry_busy),
      .head      (head)
   );

   // Handshake, writeback decode and next-state for the divider and inflight counters
   always_comb begin
      div_busy   = div_cnt_q != 4'd0;
      req_ready  = ~rst & ~flush & ~qry_busy & ~(op == DIV && div_busy);
      dp_issue   = req_valid & req_ready;
      dp_op      = dp_issue ? req_op : 3'd0;
      ins_slot   = '{valid: 1'b1, op: op, tag: req_tag, illegal: op == ILL};
      wb_valid   = head.valid & ~flush;
      wb_op      = wb_valid ? head.op : 3'd0;
      wb_tag     = wb_valid ? head.tag : '0;
      wb_illegal = wb_valid & head.illegal;
      inflight   = inflight_q;
      div_cnt_d  = flush                    ? 4'd0 :
                   (dp_issue && op == DIV)  ? 4'(LAT_DIV - 1) :
                   div_busy                 ? div_cnt_q - 4'd1 : div_cnt_q;
      inflight_d = flush ? 4'd0 : inflight_q + {3'd0, dp_issue} - {3'd0, wb_valid};
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q  <= 4'd0;
         inflight_q <= 4'd0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed and randomized checks of fpu_sched against a queue-based model
module tb_fpu_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_op = 3'd0;
   logic [4:0] req_tag = 5'd0;
   logic       flush = 1'b0;
   logic       dp_issue;
   logic [2:0] dp_op;
   logic       wb_valid;
   logic [2:0] wb_op;
   logic [4:0] wb_tag;
   logic       wb_illegal;
   logic       div_busy;
   logic [3:0] inflight;

   int tests_run = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      int         due;
      logic [2:0] op;
      logic [4:0] tag;
   } ent_t;
   ent_t pend[$];

   fpu_sched dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_tag(req_tag), .flush(flush), .dp_issue(dp_issue),
      .dp_op(dp_op), .wb_valid(wb_valid), .wb_op(wb_op), .wb_tag(wb_tag),
      .wb_illegal(wb_illegal), .div_busy(div_busy), .inflight(inflight)
   );

   always #5 clk = ~clk;

   function automatic int m_lat(logic [2:0] op);
      case (op)
         3'd0, 3'd1: return 2;
         3'd2:       return 3;
         3'd3:       return 8;
         default:    return 1;
      endcase
   endfunction

   function automatic bit m_div_busy();
      foreach (pend[i]) if (pend[i].op == 3'd3 && pend[i].due > cyc) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready(logic [2:0] op, logic fl);
      if (fl) return 1'b0;
      foreach (pend[i]) if (pend[i].due == cyc + m_lat(op)) return 1'b0;
      if (op == 3'd3 && m_div_busy()) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int m_wb_idx();
      foreach (pend[i]) if (pend[i].due == cyc) return i;
      return -1;
   endfunction

   task automatic set_in(input logic v, input logic [2:0] op, input logic [4:0] tag, input logic fl);
      req_valid = v;
      req_op    = op;
      req_tag   = tag;
      flush     = fl;
      #1;
   endtask

   task automatic tick();
      bit hs;
      hs = req_valid && m_ready(req_op, flush);
      @(posedge clk);
      if (flush) pend.delete();
      else begin
         for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due == cyc) pend.delete(i);
         if (hs) pend.push_back('{cyc + m_lat(req_op), req_op, req_tag});
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b1, 3'd0, 5'd3, 1'b0);
      tests_run++;
      if ({req_ready, dp_issue, wb_valid, wb_op, wb_tag, wb_illegal, div_busy, inflight} !== 16'd0) begin
         fails++;
         $display("FAIL reset_outputs got=%h want=0", {req_ready, dp_issue, wb_valid, wb_op, wb_tag, wb_illegal, div_busy, inflight});
      end
      @(negedge clk);
      rst = 1'b0;
      pend.delete();
      cyc = 0;
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
   endtask

   task automatic test_add();
      set_in(1'b1, 3'd0, 5'd3, 1'b0);
      tests_run++;
      if (dp_issue !== 1'b1) begin fails++; $display("FAIL add_issue got=%b want=1", dp_issue); end
      tick();
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
      tests_run++;
      if (inflight !== 4'd1 || wb_valid !== 1'b0) begin fails++; $display("FAIL add_t1 inflight=%0d wb=%b want 1/0", inflight, wb_valid); end
      tick();
      tests_run++;
      if ({wb_valid, wb_op, wb_tag} !== {1'b1, 3'd0, 5'd3}) begin fails++; $display("FAIL add_wb got=%b/%0d/%0d want 1/0/3", wb_valid, wb_op, wb_tag); end
      tick();
      tests_run++;
      if (inflight !== 4'd0 || wb_valid !== 1'b0) begin fails++; $display("FAIL add_t3 inflight=%0d wb=%b want 0/0", inflight, wb_valid); end
   endtask

   task automatic test_collision();
      set_in(1'b1, 3'd2, 5'd1, 1'b0);
      tests_run++;
      if (dp_op !== 3'd2) begin fails++; $display("FAIL mul_dp_op got=%0d want=2", dp_op); end
      tick();
      set_in(1'b1, 3'd0, 5'd2, 1'b0);
      tests_run++;
      if (req_ready !== 1'b0) begin fails++; $display("FAIL collide_block got=%b want=0", req_ready); end
      tick();
      set_in(1'b1, 3'd0, 5'd2, 1'b0);
      tests_run++;
      if (req_ready !== 1'b1) begin fails++; $display("FAIL collide_accept got=%b want=1", req_ready); end
      tick();
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
      tests_run++;
      if ({wb_valid, wb_op, wb_tag} !== {1'b1, 3'd2, 5'd1}) begin fails++; $display("FAIL mul_wb got=%b/%0d/%0d want 1/2/1", wb_valid, wb_op, wb_tag); end
      tick();
      tests_run++;
      if ({wb_valid, wb_op, wb_tag} !== {1'b1, 3'd0, 5'd2}) begin fails++; $display("FAIL add2_wb got=%b/%0d/%0d want 1/0/2", wb_valid, wb_op, wb_tag); end
      drain(2);
   endtask

   task automatic test_div();
      set_in(1'b1, 3'd3, 5'd4, 1'b0);
      tick();
      for (int t = 1; t <= 7; t++) begin
         set_in(1'b1, 3'd3, 5'd5, 1'b0);
         tests_run++;
         if (req_ready !== 1'b0 || div_busy !== 1'b1) begin fails++; $display("FAIL div_hold t=%0d ready=%b busy=%b want 0/1", t, req_ready, div_busy); end
         tick();
      end
      set_in(1'b1, 3'd3, 5'd5, 1'b0);
      tests_run++;
      if ({req_ready, div_busy, wb_valid, wb_op, wb_tag} !== {1'b1, 1'b0, 1'b1, 3'd3, 5'd4})
         begin fails++; $display("FAIL div_t8 got ready=%b busy=%b wb=%b op=%0d tag=%0d want 1/0/1/3/4", req_ready, div_busy, wb_valid, wb_op, wb_tag); end
      tick();
      for (int t = 9; t <= 15; t++) begin
         set_in(1'b0, 3'd0, 5'd0, 1'b0);
         tests_run++;
         if (div_busy !== 1'b1 || wb_valid !== 1'b0) begin fails++; $display("FAIL div2_busy t=%0d busy=%b wb=%b want 1/0", t, div_busy, wb_valid); end
         tick();
      end
      tests_run++;
      if ({div_busy, wb_valid, wb_tag} !== {1'b0, 1'b1, 5'd5}) begin fails++; $display("FAIL div2_wb busy=%b wb=%b tag=%0d want 0/1/5", div_busy, wb_valid, wb_tag); end
      drain(1);
   endtask

   task automatic test_out_of_order();
      int peak = 0;
      for (int t = 0; t <= 9; t++) begin
         if (t == 0) set_in(1'b1, 3'd3, 5'd6, 1'b0);
         else if (t == 1) set_in(1'b1, 3'd4, 5'd7, 1'b0);
         else set_in(1'b0, 3'd0, 5'd0, 1'b0);
         if (int'(inflight) > peak) peak = int'(inflight);
         if (t == 2) begin
            tests_run++;
            if ({wb_valid, wb_op, wb_tag} !== {1'b1, 3'd4, 5'd7}) begin fails++; $display("FAIL ooo_eq got=%b/%0d/%0d want 1/4/7", wb_valid, wb_op, wb_tag); end
         end
         if (t == 8) begin
            tests_run++;
            if ({wb_valid, wb_op, wb_tag} !== {1'b1, 3'd3, 5'd6}) begin fails++; $display("FAIL ooo_div got=%b/%0d/%0d want 1/3/6", wb_valid, wb_op, wb_tag); end
         end
         tick();
      end
      tests_run++;
      if (peak != 2) begin fails++; $display("FAIL ooo_peak got=%0d want=2", peak); end
   endtask

   task automatic test_flush();
      set_in(1'b1, 3'd0, 5'd1, 1'b0);
      tick();
      set_in(1'b1, 3'd2, 5'd2, 1'b0);
      tick();
      set_in(1'b1, 3'd4, 5'd3, 1'b1);
      tests_run++;
      if ({req_ready, dp_issue, wb_valid} !== 3'b000) begin fails++; $display("FAIL flush_cycle got=%b want=000", {req_ready, dp_issue, wb_valid}); end
      tick();
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
      tests_run++;
      if ({inflight, div_busy, req_ready} !== {4'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL flush_after inflight=%0d busy=%b ready=%b want 0/0/1", inflight, div_busy, req_ready); end
      for (int t = 3; t <= 6; t++) begin
         tests_run++;
         if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_no_wb t=%0d got=%b want=0", t, wb_valid); end
         tick();
      end
   endtask

   task automatic test_illegal();
      set_in(1'b1, 3'd7, 5'd9, 1'b0);
      tick();
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
      tests_run++;
      if ({wb_valid, wb_illegal, wb_op, wb_tag} !== {1'b1, 1'b1, 3'd7, 5'd9}) begin fails++; $display("FAIL illegal_wb got=%b/%b/%0d/%0d want 1/1/7/9", wb_valid, wb_illegal, wb_op, wb_tag); end
      tick();
   endtask

   task automatic test_reset_mid();
      set_in(1'b1, 3'd3, 5'd10, 1'b0);
      tick();
      set_in(1'b0, 3'd0, 5'd0, 1'b0);
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      tests_run++;
      if ({req_ready, dp_issue, wb_valid, wb_op, wb_tag, wb_illegal, div_busy, inflight} !== 16'd0) begin
         fails++;
         $display("FAIL reset_mid got=%h want=0", {req_ready, dp_issue, wb_valid, wb_op, wb_tag, wb_illegal, div_busy, inflight});
      end
      @(negedge clk);
      rst = 1'b0;
      pend.delete();
      cyc = 0;
      for (int t = 0; t < 10; t++) begin
         #1;
         tests_run++;
         if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_no_wb t=%0d got=%b want=0", t, wb_valid); end
         tick();
      end
   endtask

   task automatic test_random();
      logic       v = 1'b0;
      logic [2:0] op = 3'd0;
      logic [4:0] tag = 5'd0;
      logic       fl;
      logic       hold = 1'b0;
      logic [18:0] got, want;
      int idx;
      for (int n = 0; n < 600; n++) begin
         if (!hold) begin
            v   = $urandom_range(0, 3) != 0;
            op  = 3'($urandom);
            tag = 5'($urandom);
         end
         fl = $urandom_range(0, 24) == 0;
         set_in(v, op, tag, fl);
         idx = fl ? -1 : m_wb_idx();
         want = {m_ready(op, fl), v && m_ready(op, fl), (v && m_ready(op, fl)) ? op : 3'd0,
                 idx >= 0, idx >= 0 ? pend[idx].op : 3'd0, idx >= 0 ? pend[idx].tag : 5'd0,
                 idx >= 0 && pend[idx].op == 3'd7, m_div_busy(), 4'(pend.size())};
         got = {req_ready, dp_issue, dp_op, wb_valid, wb_op, wb_tag, wb_illegal, div_busy, inflight};
         tests_run++;
         if (got !== want) begin fails++; $display("FAIL random n=%0d got=%h want=%h", n, got, want); end
         hold = v && !m_ready(op, fl);
         tick();
      end
      drain(10);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_add();
      test_collision();
      test_div();
      test_out_of_order();
      test_flush();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
